// File: rtl/cva6_tlb_sv32_plru_if.sv
// Lookup, update and flush bundle for the parametrised Sv32 TLB.
// The TLB side uses the slave modport; the MMU/PTW side uses the master modport.
interface cva6_tlb_sv32_plru_if #(
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  flush_i;
    logic [ASID_WIDTH-1:0] asid_to_be_flushed_i;
    logic [31:0]           vaddr_to_be_flushed_i;
    logic                  update_valid_i;
    logic                  update_is_4M_i;
    logic [19:0]           update_vpn_i;
    logic [ASID_WIDTH-1:0] update_asid_i;
    logic [31:0]           update_content_i;
    logic                  lu_access_i;
    logic [ASID_WIDTH-1:0] lu_asid_i;
    logic [31:0]           lu_vaddr_i;
    logic                  lu_valid_o;
    logic                  lu_hit_o;
    logic                  lu_is_4M_o;
    logic [31:0]           lu_content_o;
    logic [CNT_WIDTH-1:0]  hit_cnt_o;
    logic [CNT_WIDTH-1:0]  miss_cnt_o;

    modport master (
        output flush_i, asid_to_be_flushed_i, vaddr_to_be_flushed_i,
        output update_valid_i, update_is_4M_i, update_vpn_i, update_asid_i, update_content_i,
        output lu_access_i, lu_asid_i, lu_vaddr_i,
        input  lu_valid_o, lu_hit_o, lu_is_4M_o, lu_content_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  flush_i, asid_to_be_flushed_i, vaddr_to_be_flushed_i,
        input  update_valid_i, update_is_4M_i, update_vpn_i, update_asid_i, update_content_i,
        input  lu_access_i, lu_asid_i, lu_vaddr_i,
        output lu_valid_o, lu_hit_o, lu_is_4M_o, lu_content_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/cva6_tlb_sv32_plru.sv
// Fully-associative Sv32 TLB with tree-PLRU replacement, registered lookup
// and saturating hit/miss counters.
module cva6_tlb_sv32_plru #(
    parameter int unsigned TLB_ENTRIES = 4,
    parameter int unsigned ASID_WIDTH  = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    cva6_tlb_sv32_plru_if.slave  tlb
);
    localparam int unsigned IDX_W  = $clog2(TLB_ENTRIES);
    localparam int unsigned PLRU_W = TLB_ENTRIES - 1;

    typedef struct packed {
        logic                  valid;
        logic                  is_4m;
        logic [9:0]            vpn1;
        logic [9:0]            vpn0;
        logic [ASID_WIDTH-1:0] asid;
        logic                  g;
    } tag_t;

    tag_t                 tags_q    [TLB_ENTRIES];
    tag_t                 tags_d    [TLB_ENTRIES];
    logic [31:0]          content_q [TLB_ENTRIES];
    logic [31:0]          content_d [TLB_ENTRIES];
    logic [PLRU_W-1:0]    plru_q, plru_d;
    logic                 lu_valid_q, lu_valid_d;
    logic                 lu_hit_q, lu_hit_d;
    logic                 lu_is_4m_q, lu_is_4m_d;
    logic [31:0]          lu_content_q, lu_content_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic                 lu_hit_c, dup_c, inv_c, lu_eff_hit_c;
    logic [IDX_W-1:0]     lu_idx_c, dup_idx_c, inv_idx_c, upd_idx_c;
    logic [19:0]          lu_vpn_c, fl_vpn_c;

    assign lu_vpn_c = tlb.lu_vaddr_i[31:12];
    assign fl_vpn_c = tlb.vaddr_to_be_flushed_i[31:12];

    function automatic logic vpn_match(input tag_t e, input logic [19:0] vpn);
        return (e.vpn1 == vpn[19:10]) && (e.is_4m || (e.vpn0 == vpn[9:0]));
    endfunction

    // Point every node on entry k's path away from k.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] t,
                                                      input logic [IDX_W-1:0]  k);
        logic [PLRU_W-1:0] r;
        int unsigned       node;
        logic              right;
        r = t;
        for (int unsigned l = 0; l < IDX_W; l++) begin
            node  = ((32'd1 << l) - 32'd1) + (32'(k) >> (IDX_W - l));
            right = ((32'(k) >> (IDX_W - 32'd1 - l)) & 32'd1) != 32'd0;
            r     = (r & ~(PLRU_W'(1) << node)) | (PLRU_W'(!right) << node);
        end
        return r;
    endfunction

    function automatic logic [IDX_W-1:0] plru_victim(input logic [PLRU_W-1:0] t);
        int unsigned node;
        node = 32'd0;
        for (int unsigned l = 0; l < IDX_W; l++) begin
            node = 32'd2 * node + 32'd1 + 32'((t >> node) & PLRU_W'(1));
        end
        return IDX_W'(node - PLRU_W);
    endfunction

    // Associative searches; descending loop leaves the lowest matching index.
    always_comb begin
        lu_hit_c  = 1'b0;
        lu_idx_c  = '0;
        dup_c     = 1'b0;
        dup_idx_c = '0;
        inv_c     = 1'b0;
        inv_idx_c = '0;
        for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
            if (tags_q[i].valid && (tags_q[i].g || (tags_q[i].asid == tlb.lu_asid_i))
                && vpn_match(tags_q[i], lu_vpn_c)) begin
                lu_hit_c = 1'b1;
                lu_idx_c = IDX_W'(i);
            end
            if (tags_q[i].valid && (tags_q[i].is_4m == tlb.update_is_4M_i)
                && (tags_q[i].asid == tlb.update_asid_i)
                && (tags_q[i].vpn1 == tlb.update_vpn_i[19:10])
                && (tlb.update_is_4M_i || (tags_q[i].vpn0 == tlb.update_vpn_i[9:0]))) begin
                dup_c     = 1'b1;
                dup_idx_c = IDX_W'(i);
            end
            if (!tags_q[i].valid) begin
                inv_c     = 1'b1;
                inv_idx_c = IDX_W'(i);
            end
        end
        upd_idx_c = dup_c ? dup_idx_c : (inv_c ? inv_idx_c : plru_victim(plru_q));
    end

    // Next state: lookup result, counters, flush, then hit/update PLRU order.
    always_comb begin
        tags_d       = tags_q;
        content_d    = content_q;
        plru_d       = plru_q;
        lu_valid_d   = tlb.lu_access_i;
        lu_hit_d     = lu_hit_q;
        lu_is_4m_d   = lu_is_4m_q;
        lu_content_d = lu_content_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        lu_eff_hit_c = tlb.lu_access_i && lu_hit_c && !tlb.flush_i;

        if (tlb.lu_access_i) begin
            lu_hit_d     = lu_eff_hit_c;
            lu_is_4m_d   = lu_eff_hit_c && tags_q[lu_idx_c].is_4m;
            lu_content_d = lu_eff_hit_c ? content_q[lu_idx_c] : 32'h0;
            if (lu_eff_hit_c) begin
                if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
            end else begin
                if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (tlb.flush_i) begin
            for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
                if (((tlb.vaddr_to_be_flushed_i == 32'h0) || vpn_match(tags_q[i], fl_vpn_c))
                    && ((tlb.asid_to_be_flushed_i == '0)
                        || ((tags_q[i].asid == tlb.asid_to_be_flushed_i) && !tags_q[i].g))) begin
                    tags_d[i].valid = 1'b0;
                end
            end
        end else begin
            if (lu_eff_hit_c) plru_d = plru_touch(plru_d, lu_idx_c);
            if (tlb.update_valid_i) begin
                tags_d[upd_idx_c].valid = 1'b1;
                tags_d[upd_idx_c].is_4m = tlb.update_is_4M_i;
                tags_d[upd_idx_c].vpn1  = tlb.update_vpn_i[19:10];
                tags_d[upd_idx_c].vpn0  = tlb.update_vpn_i[9:0];
                tags_d[upd_idx_c].asid  = tlb.update_asid_i;
                tags_d[upd_idx_c].g     = tlb.update_content_i[5];
                content_d[upd_idx_c]    = tlb.update_content_i;
                plru_d                  = plru_touch(plru_d, upd_idx_c);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
                tags_q[i]    <= '0;
                content_q[i] <= '0;
            end
            plru_q       <= '0;
            lu_valid_q   <= 1'b0;
            lu_hit_q     <= 1'b0;
            lu_is_4m_q   <= 1'b0;
            lu_content_q <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
                tags_q[i]    <= tags_d[i];
                content_q[i] <= content_d[i];
            end
            plru_q       <= plru_d;
            lu_valid_q   <= lu_valid_d;
            lu_hit_q     <= lu_hit_d;
            lu_is_4m_q   <= lu_is_4m_d;
            lu_content_q <= lu_content_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign tlb.lu_valid_o   = lu_valid_q;
    assign tlb.lu_hit_o     = lu_hit_q;
    assign tlb.lu_is_4M_o   = lu_is_4m_q;
    assign tlb.lu_content_o = lu_content_q;
    assign tlb.hit_cnt_o    = hit_cnt_q;
    assign tlb.miss_cnt_o   = miss_cnt_q;

endmodule
